nios_system_nios2_car_controll_oci_dtrace_packer: RTL and testbench

- Data-trace packing stage for the car-control Nios II OCI.
- Collects 2-bit trace symbols into a 30-bit frame buffer with a 4-bit fill count, and presents that buffer live on dct_buffer/dct_count, which feed the OCI test bench.
- Hands completed or flushed frames downstream through a valid/ready output register.
- Generates the test_ending/test_has_ended status pair consumed by the OCI test bench.

---
 rtl/nios_system_nios2_car_controll_oci_dtrace_packer.sv | 149 ++++++++++++++
 tb/tb_nios_system_nios2_car_controll_oci_dtrace_packer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_nios2_car_controll_oci_dtrace_packer.sv
// Data-trace packer for the car-control OCI: packs 2-bit trace symbols into
// 15-slot frames and hands them downstream through a valid/ready register.
module nios_system_nios2_car_controll_oci_dtrace_packer #(
    parameter int SYM_W  = 2,
    parameter int SLOTS  = 15,
    parameter int DROP_W = 8,
    localparam int BUF_W = SYM_W * SLOTS,
    localparam int CNT_W = $clog2(SLOTS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_start,
    input  logic              trace_stop,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BUF_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              test_ending,
    output logic              test_has_ended,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  dctBuffer_q, dctBuffer_d;
    logic [CNT_W-1:0]  dctCount_q, dctCount_d;
    logic [BUF_W-1:0]  outData_q, outData_d;
    logic [CNT_W-1:0]  outCount_q, outCount_d;
    logic              outValid_q, outValid_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] dropCount_q, dropCount_d;
    logic              testEnding_q, testHasEnded_q;
    logic              accept, outFree;

    assign accept  = outValid_q && out_ready;
    assign outFree = !outValid_q || out_ready;

    // Transfers are evaluated before inserts so that a symbol arriving in the
    // transfer cycle lands in slot 0 of the freshly cleared buffer.
    always_comb begin
        state_d     = state_q;
        dctBuffer_d = dctBuffer_q;
        dctCount_d  = dctCount_q;
        outData_d   = outData_q;
        outCount_d  = outCount_q;
        outValid_d  = outValid_q;
        overflow_d  = overflow_q;
        dropCount_d = dropCount_q;

        if (accept) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            IDLE, DONE: begin
                if (trace_start) begin
                    state_d     = RUN;
                    dctBuffer_d = '0;
                    dctCount_d  = '0;
                    overflow_d  = 1'b0;
                    dropCount_d = '0;
                end
            end
            RUN: begin
                if (dctCount_q == FULL && outFree) begin
                    outData_d   = dctBuffer_q;
                    outCount_d  = FULL;
                    outValid_d  = 1'b1;
                    dctBuffer_d = '0;
                    dctCount_d  = '0;
                end
                if (sym_valid) begin
                    if (dctCount_d != FULL) begin
                        dctBuffer_d[int'(dctCount_d) * SYM_W +: SYM_W] = sym_data;
                        dctCount_d = dctCount_d + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                        if (dropCount_q != '1) begin
                            dropCount_d = dropCount_q + DROP_W'(1);
                        end
                    end
                end
                if (trace_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Unused upper slots are already zero since inserts only ever
                // fill the buffer from slot 0 upward after a clear.
                if (dctCount_q != '0 && outFree) begin
                    outData_d   = dctBuffer_q;
                    outCount_d  = dctCount_q;
                    outValid_d  = 1'b1;
                    dctBuffer_d = '0;
                    dctCount_d  = '0;
                end
                if (dctCount_q == '0 && outFree) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            dctBuffer_q    <= '0;
            dctCount_q     <= '0;
            outData_q      <= '0;
            outCount_q     <= '0;
            outValid_q     <= 1'b0;
            overflow_q     <= 1'b0;
            dropCount_q    <= '0;
            testEnding_q   <= 1'b0;
            testHasEnded_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dctBuffer_q    <= dctBuffer_d;
            dctCount_q     <= dctCount_d;
            outData_q      <= outData_d;
            outCount_q     <= outCount_d;
            outValid_q     <= outValid_d;
            overflow_q     <= overflow_d;
            dropCount_q    <= dropCount_d;
            testEnding_q   <= (state_d == DRAIN);
            testHasEnded_q <= (state_d == DONE);
        end
    end

    assign out_valid      = outValid_q;
    assign out_data       = outData_q;
    assign out_count      = outCount_q;
    assign dct_buffer     = dctBuffer_q;
    assign dct_count      = dctCount_q;
    assign test_ending    = testEnding_q;
    assign test_has_ended = testHasEnded_q;
    assign overflow       = overflow_q;
    assign drop_count     = dropCount_q;

endmodule

// File: tb/tb_nios_system_nios2_car_controll_oci_dtrace_packer.sv
// Scoreboard bench for the dtrace packer: a queue-based reference model
// predicts frames and live status; a negedge monitor compares the DUT.
module tb_nios_system_nios2_car_controll_oci_dtrace_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_start = 1'b0;
    logic        trace_stop = 1'b0;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym_data = 2'b00;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        overflow;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    nios_system_nios2_car_controll_oci_dtrace_packer dut (
        .clk(clk), .reset(reset), .trace_start(trace_start), .trace_stop(trace_stop),
        .sym_valid(sym_valid), .sym_data(sym_data), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .overflow(overflow), .drop_count(drop_count)
    );

    typedef struct {
        logic [29:0] data;
        int          cnt;
    } frame_t;

    int         checks = 0;
    int         errors = 0;
    bit         monitorOn = 0;

    // Reference model: 0 idle, 1 run, 2 drain, 3 done.
    int         mState = 0;
    logic [1:0] cur[$];
    bit         mHold = 0;
    bit         mOvf = 0;
    int         mDrops = 0;
    frame_t     expQ[$];

    function automatic logic [29:0] packCur();
        logic [29:0] r = '0;
        foreach (cur[i]) r = r | (30'(cur[i]) << (2 * i));
        return r;
    endfunction

    function automatic void emitFrame();
        frame_t f;
        f.data = packCur();
        f.cnt  = cur.size();
        expQ.push_back(f);
        mHold = 1;
        cur.delete();
    endfunction

    function automatic void modelStep();
        bit accept = mHold && out_ready;
        bit free   = !mHold || out_ready;
        if (reset) begin
            mState = 0; cur.delete(); mHold = 0; mOvf = 0; mDrops = 0; expQ.delete();
            return;
        end
        if (accept) mHold = 0;
        case (mState)
            0, 3: if (trace_start) begin
                mState = 1; cur.delete(); mOvf = 0; mDrops = 0;
            end
            1: begin
                if (cur.size() == 15 && free) emitFrame();
                if (sym_valid) begin
                    if (cur.size() < 15) cur.push_back(sym_data);
                    else begin
                        mOvf = 1;
                        if (mDrops < 255) mDrops++;
                    end
                end
                if (trace_stop) mState = 2;
            end
            default: begin
                if (cur.size() == 0 && free) mState = 3;
                else if (free) emitFrame();
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: live status every cycle, frame contents on each handshake.
    always @(negedge clk) begin
        if (monitorOn) begin
            frame_t f;
            checkOutput("out_valid", 32'(out_valid), 32'(mHold));
            checkOutput("dct_count", 32'(dct_count), 32'(cur.size()));
            checkOutput("dct_buffer", 32'(dct_buffer), 32'(packCur()));
            checkOutput("overflow", 32'(overflow), 32'(mOvf));
            checkOutput("drop_count", 32'(drop_count), 32'(mDrops));
            checkOutput("test_ending", 32'(test_ending), 32'(mState == 2));
            checkOutput("test_has_ended", 32'(test_has_ended), 32'(mState == 3));
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL out_frame: got handshake 0x%0h, expected no frame", out_data);
                end else begin
                    f = expQ.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(f.data));
                    checkOutput("out_count", 32'(out_count), 32'(f.cnt));
                end
            end
        end
    end

    task automatic applyStimulus(input bit v, input logic [1:0] d, input bit st, input bit sp, input bit rdy);
        sym_valid   = v;
        sym_data    = d;
        trace_start = st;
        trace_stop  = sp;
        out_ready   = rdy;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 2'b00, 0, 0, rdy);
    endtask

    task automatic sendSyms(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1, 2'((i + 1) % 4), 0, 0, rdy);
    endtask

    task automatic waitDone();
        applyStimulus(0, 2'b00, 0, 1, 1);
        for (int i = 0; i < 100 && !test_has_ended; i++) idle(1, 1);
        checkOutput("done_reached", 32'(test_has_ended), 32'd1);
    endtask

    initial begin
        idle(2, 0);
        monitorOn = 1;
        reset = 1'b0;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);

        // Single full frame
        applyStimulus(0, 2'b00, 1, 0, 1);
        sendSyms(15, 1);
        idle(4, 1);
        waitDone();

        // Back-to-back frames
        applyStimulus(0, 2'b00, 1, 0, 1);
        sendSyms(30, 1);
        idle(4, 1);
        waitDone();

        // Overflow with a stalled consumer
        applyStimulus(0, 2'b00, 1, 0, 0);
        sendSyms(35, 0);
        checkOutput("ovf_drop_count", 32'(drop_count), 32'd5);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_dct_count", 32'(dct_count), 32'd15);
        idle(4, 1);
        waitDone();

        // Partial frame drain
        applyStimulus(0, 2'b00, 1, 0, 0);
        sendSyms(7, 0);
        applyStimulus(0, 2'b00, 0, 1, 0);
        idle(2, 0);
        checkOutput("drain_ending", 32'(test_ending), 32'd1);
        checkOutput("drain_out_count", 32'(out_count), 32'd7);
        checkOutput("drain_upper_zero", 32'(out_data[29:14]), 32'd0);
        waitDone();
        checkOutput("drain_not_ending", 32'(test_ending), 32'd0);

        // Empty stop
        applyStimulus(0, 2'b00, 1, 0, 1);
        applyStimulus(0, 2'b00, 0, 1, 1);
        checkOutput("empty_ending", 32'(test_ending), 32'd1);
        idle(1, 1);
        checkOutput("empty_done", 32'(test_has_ended), 32'd1);
        checkOutput("empty_no_valid", 32'(out_valid), 32'd0);

        // Reset during drain with a stalled consumer
        applyStimulus(0, 2'b00, 1, 0, 0);
        sendSyms(5, 0);
        applyStimulus(0, 2'b00, 0, 1, 0);
        idle(2, 0);
        reset = 1'b1;
        idle(1, 0);
        reset = 1'b0;
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_ending", 32'(test_ending), 32'd0);
        applyStimulus(0, 2'b00, 1, 0, 1);
        sendSyms(15, 1);
        idle(4, 1);
        waitDone();

        // Randomized traffic with occasional start/stop/reset
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0,
                          $urandom_range(0, 1) == 1);
        end
        reset = 1'b0;
        applyStimulus(0, 2'b00, 1, 0, 1);
        waitDone();
        idle(3, 1);
        checkOutput("frames_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
